// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU issue sequencer: ALU opcodes, the MUL command code,
// the FSM state encoding and the shift-add iteration count. MUL states depend on ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam logic [2:0] OpZero = 3'd0;
  localparam logic [2:0] OpAdd  = 3'd1;
  localparam logic [2:0] OpSub  = 3'd2;
  localparam logic [2:0] OpAnd  = 3'd3;
  localparam logic [2:0] OpOr   = 3'd4;
  localparam logic [2:0] OpGt   = 3'd5;
  localparam logic [2:0] OpEq   = 3'd6;
  localparam logic [2:0] OpShl  = 3'd7;

  localparam logic [3:0] CmdMul = 4'd8;

  localparam int unsigned MulIters = 16;
  localparam int unsigned MulCntW  = $clog2(MulIters);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StExec   = 3'd1,
`ifdef ALU_SEQ_MUL_EN
    StMulAdd = 3'd2,
    StMulShl = 3'd3,
`endif
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_issue_seq.sv
// Command sequencer driving an external ALU; op 8 is a 16-step shift-add multiply when
// ALU_SEQ_MUL_EN is defined, otherwise it is reported as an illegal command.
module alu_issue_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [2:0]  Upr_ALU,
  output logic [31:0] A_alu,
  output logic [31:0] B_alu,
  input  logic [31:0] Out_ALU,
  input  logic        C,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_flag,
  output logic        res_err
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_flag_q, res_flag_d;
  logic        res_err_q, res_err_d;

`ifdef ALU_SEQ_MUL_EN
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        m_q, m_d;
  logic [15:0]        mulq_q, mulq_d;
  logic [MulCntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_flag_d = res_flag_q;
    res_err_d  = res_err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d      = acc_q;
    m_d        = m_q;
    mulq_d     = mulq_q;
    cnt_d      = cnt_q;
`endif
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    Upr_ALU    = OpZero;
    A_alu      = '0;
    B_alu      = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d = cmd_op[2:0];
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (!cmd_op[3]) begin
            state_d = StExec;
`ifdef ALU_SEQ_MUL_EN
          end else if (cmd_op == CmdMul) begin
            // Only the low half of cmd_b drives the multiplier bits.
            acc_d   = '0;
            m_d     = cmd_a;
            mulq_d  = cmd_b[15:0];
            cnt_d   = '0;
            state_d = StMulAdd;
`endif
          end else begin
            res_data_d = '0;
            res_flag_d = 1'b0;
            res_err_d  = 1'b1;
            state_d    = StDone;
          end
        end
      end

      StExec: begin
        Upr_ALU    = op_q;
        A_alu      = a_q;
        B_alu      = b_q;
        res_data_d = Out_ALU;
        res_flag_d = C;
        res_err_d  = 1'b0;
        state_d    = StDone;
      end

`ifdef ALU_SEQ_MUL_EN
      StMulAdd: begin
        Upr_ALU = OpAdd;
        A_alu   = acc_q;
        B_alu   = m_q;
        if (mulq_q[0]) acc_d = Out_ALU;
        state_d = StMulShl;
      end

      StMulShl: begin
        Upr_ALU = OpShl;
        A_alu   = m_q;
        B_alu   = '0;
        m_d     = Out_ALU;
        mulq_d  = mulq_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == MulCntW'(MulIters - 1)) begin
          // The final shift does not touch acc, so acc already holds the product.
          res_data_d = acc_q;
          res_flag_d = 1'b0;
          res_err_d  = 1'b0;
          state_d    = StDone;
        end else begin
          state_d = StMulAdd;
        end
      end
`endif

      StDone: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_flag_q <= 1'b0;
      res_err_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q      <= '0;
      m_q        <= '0;
      mulq_q     <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_flag_q <= res_flag_d;
      res_err_q  <= res_err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q      <= acc_d;
      m_q        <= m_d;
      mulq_q     <= mulq_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign res_data = res_data_q;
  assign res_flag = res_flag_q;
  assign res_err  = res_err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: models the neighbouring ALU and checks results against a
// reference computed directly from the command semantics.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  Upr_ALU;
  logic [31:0] A_alu, B_alu;
  logic [31:0] Out_ALU;
  logic        C;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_flag;
  logic        res_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .Upr_ALU  (Upr_ALU),
    .A_alu    (A_alu),
    .B_alu    (B_alu),
    .Out_ALU  (Out_ALU),
    .C        (C),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_flag (res_flag),
    .res_err  (res_err)
  );

  // Neighbouring combinational ALU.
  always_comb begin
    Out_ALU = '0;
    C       = 1'b0;
    case (Upr_ALU)
      3'd1: Out_ALU = A_alu + B_alu;
      3'd2: Out_ALU = A_alu - B_alu;
      3'd3: Out_ALU = A_alu & B_alu;
      3'd4: Out_ALU = A_alu | B_alu;
      3'd5: C = (A_alu > B_alu);
      3'd6: C = (A_alu == B_alu);
      3'd7: Out_ALU = A_alu << 1;
      default: ;
    endcase
  end

  // Reference: expected {data, flag, err} and accept-to-valid latency for one command.
  function automatic void ref_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [33:0] exp, output int lat);
    longint unsigned prod;
    exp = '0;
    lat = 2;
    case (op)
      4'd0: exp = {32'd0, 2'b00};
      4'd1: exp = {a + b, 2'b00};
      4'd2: exp = {a - b, 2'b00};
      4'd3: exp = {a & b, 2'b00};
      4'd4: exp = {a | b, 2'b00};
      4'd5: exp = {32'd0, (a > b), 1'b0};
      4'd6: exp = {32'd0, (a == b), 1'b0};
      4'd7: exp = {a << 1, 2'b00};
`ifdef ALU_SEQ_MUL_EN
      4'd8: begin
        prod = longint'(a) * longint'(b[15:0]);
        exp  = {prod[31:0], 2'b00};
        lat  = 33;
      end
`endif
      default: begin
        exp = {32'd0, 2'b01};
        lat = 1;
      end
    endcase
  endfunction

  // Issues one command, checks latency and result, holds res_ready low for 'hold' cycles.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string name);
    logic [33:0] exp;
    logic [33:0] held;
    int          lat;
    int          cyc;
    ref_cmd(op, a, b, exp, lat);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_ready: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = $urandom();
    cmd_a     = $urandom();
    cmd_b     = $urandom();
    cyc = 1;
    while (!res_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (cyc !== lat || res_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, cyc, res_valid, lat);
    end
    tests++;
    if ({res_data, res_flag, res_err} !== exp) begin
      fails++;
      $display("FAIL %s result: got data=%h flag=%b err=%b want data=%h flag=%b err=%b",
               name, res_data, res_flag, res_err, exp[33:2], exp[1], exp[0]);
    end
    held = {res_data, res_flag, res_err};
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({res_valid, cmd_ready, res_data, res_flag, res_err} !== {2'b10, held} ||
          {Upr_ALU, A_alu, B_alu} !== 67'd0) begin
        fails++;
        $display("FAIL %s hold%0d: valid=%b ready=%b data=%h upr=%0d a=%h b=%h want 1 0 %h 0 0 0",
                 name, i, res_valid, cmd_ready, res_data, Upr_ALU, A_alu, B_alu, held[33:2]);
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    tests++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL %s release: valid=%b ready=%b want 0 1", name, res_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({cmd_ready, res_valid, res_data, res_flag, res_err, Upr_ALU, A_alu, B_alu} !==
        {2'b10, 101'd0}) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h upr=%0d a=%h b=%h want 1 0 0 0 0 0",
               cmd_ready, res_valid, res_data, Upr_ALU, A_alu, B_alu);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_cmd(4'd1, 32'd5, 32'd7, 0, "add_5_7");
    run_cmd(4'd5, 32'd9, 32'd3, 0, "gt_9_3");
    run_cmd(4'd6, 32'hDEADBEEF, 32'hDEADBEEF, 0, "eq_same");
    run_cmd(4'd8, 32'h1234, 32'hFFFF0010, 0, "mul_1234");
    run_cmd(4'd8, 32'hFFFFFFFF, 32'd2, 0, "mul_wrap");
    run_cmd(4'hA, 32'h55, 32'h66, 0, "illegal_a");
  endtask

  task automatic test_hold();
    run_cmd(4'd2, 32'd100, 32'd1, 5, "hold_sub");
    run_cmd(4'hF, 32'd1, 32'd2, 5, "hold_illegal");
  endtask

  task automatic test_reset_mid_mul();
    cmd_valid = 1'b1;
    cmd_op    = 4'd8;
    cmd_a     = 32'h0001_0003;
    cmd_b     = 32'h0000_00FF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({cmd_ready, res_valid, res_data, res_flag, res_err, Upr_ALU, A_alu, B_alu} !==
        {2'b10, 101'd0}) begin
      fails++;
      $display("FAIL abort_outputs: ready=%b valid=%b data=%h upr=%0d a=%h b=%h want 1 0 0 0 0 0",
               cmd_ready, res_valid, res_data, Upr_ALU, A_alu, B_alu);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      tests++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL abort_no_result%0d: valid=%b ready=%b want 0 1", i, res_valid, cmd_ready);
      end
    end
    run_cmd(4'd2, 32'd10, 32'd3, 0, "after_abort_sub");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'd8;
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = a;
      run_cmd(op, a, b, int'($urandom_range(0, 3)), $sformatf("rand%0d_op%0d", n, op));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
